sd_cmd_serializer: RTL and testbench
====================================

# sd_cmd_serializer

Parametrised successor to the SD host CMD-line parallel-to-serial wrapper. It accepts an N_BITS-wide command frame, shifts it out MSB-first on the CMD line, and, when enabled, generates and inserts the CRC7 and end bit on the fly. It also drives a line output-enable and a busy/complete handshake to the CMD controller. It sits between the command-builder FSM and the CMD pad, clocked by sd_clock.

## Interface
- N_BITS, 48, total frame length in bits (≥16)
- CRC_EN, 1, 1: bits [7:1] replaced by computed CRC7 and bit 0 forced to 1; 0: frame sent verbatim
- CNT_W, $clog2(N_BITS+1), bit-counter width (derived; do not override)

Ports:
- sd_clock  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  block enable; low aborts any frame in progress
- load_send  in  1  request to capture parallel and start a frame
- parallel  in  N_BITS  frame; bit N_BITS-1 sent first
- serial  out  1  CMD line data; idles at 1
- serial_oe  out  1  pad drive enable; 1 only while frame bits are driven
- busy  out  1  frame in flight (SHIFT or DONE)
- complete  out  1  one-cycle pulse after the last bit

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: serial=1, serial_oe=0, busy=0, complete=0.
- Accept: load_send=1 and enable=1 sampled in IDLE or DONE. Captures parallel into the shift register, clears the bit counter and the CRC register to 7'h00, and moves to SHIFT. load_send in SHIFT is ignored.
- SHIFT: serial = current MSB, serial_oe=1, busy=1. Each edge shifts left by 1 and increments the counter.
- CRC (CRC_EN=1): polynomial x^7+x^3+1, serial update with each bit sent while counter < N_BITS-8.
  - Counter N_BITS-8 .. N_BITS-2: serial = crc[6] down to crc[0]; the CRC register shifts out and is not updated.
  - Counter N_BITS-1: serial=1 (end bit).
  - Captured bits [7:0] are ignored.
- CRC_EN=0: all N_BITS captured bits are sent unchanged.
- After bit N_BITS-1 is sent, the FSM goes to DONE: complete=1, busy=1, serial=1, serial_oe=0. It goes to IDLE on the next edge unless a new accept occurs.
- Abort: enable=0 in any state → IDLE on the next edge. No complete pulse; the shift register contents are irrelevant.
- reset=1: same as abort, and overrides load_send.

## Timing
- Accept sampled at edge k → bit N_BITS-1 is visible on serial from edge k through k+1. Bit i appears after edge k+(N_BITS-1-i).
- Last bit: between edges k+N_BITS-1 and k+N_BITS.
- complete and the DONE state run from edge k+N_BITS to k+N_BITS+1.
- Earliest back-to-back accept is at edge k+N_BITS+1. This guarantees exactly one idle-high (undriven) cycle between frames.
- All outputs are registered. Reset values: serial=1, serial_oe=0, busy=0, complete=0.
- Counter never wraps: it saturates its use at N_BITS-1, and leaving SHIFT clears it.

## Structure
- Package sd_cmd_pkg holds:
  - CRC7 polynomial constant 7'h09
  - CMD frame length constant 48
  - state enum {IDLE, SHIFT, DONE}
  - Shared later by the response deserializer.
- Sub-module crc7_serial: clear, enable and data-in inputs; 7-bit crc output. Reused by the CMD receive path for response checking.
- The top level holds the FSM, shift register, counter and output mux.

## Test plan
- N_BITS=48, CRC_EN=1, parallel=48'h40_0000_0000_xx (CMD0) → serial stream 48'h40_0000_0000_95; complete pulses at edge k+48; serial_oe high exactly 48 cycles.
- CMD8 frame 48'h48_0000_01AA_xx → last byte 8'h87. CMD17 frame 48'h51_0000_0000_xx → last byte 8'h55.
- CRC_EN=0, parallel=48'hA5A5_5A5A_F00F → stream identical to input, bits [7:0] included.
- Two accepts at edges k and k+49 → two correct frames, one serial=1/oe=0 cycle between them. A load_send pulse at k+10 is ignored.
- Abort cases, each → IDLE next edge, serial=1, oe=0, no complete:
  - enable dropped at bit 20
  - reset asserted at bit 30 with load_send held high
- Then a fresh frame must carry the correct CRC (CRC register cleared).
- N_BITS=136, CRC_EN=0, random payload → 136 bits out MSB-first; complete at edge k+136; counter width check.

Source files
------------

// File: rtl/sd_cmd_pkg.sv
// Shared SD CMD-line definitions: CRC7 polynomial, frame length, FSM encoding.
package sd_cmd_pkg;

  localparam int unsigned CMD_FRAME_BITS = 48;
  localparam int unsigned CRC7_W         = 7;
  localparam logic [CRC7_W-1:0] CRC7_POLY = 7'h09;  // x^7 + x^3 + 1

  // Legacy encodings kept visible for tools and waveforms that expect them.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } sd_cmd_state_e;

  // One serial CRC7 step, MSB-first data.
  function automatic logic [CRC7_W-1:0] crc7_step(input logic [CRC7_W-1:0] crc,
                                                  input logic              din);
    logic fb;
    fb = din ^ crc[CRC7_W-1];
    return {crc[CRC7_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 accumulator, shared by the CMD transmit and response paths.
module crc7_serial
  import sd_cmd_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic              din_i,
  output logic [CRC7_W-1:0] crc_o
);

  logic [CRC7_W-1:0] crc_q;
  logic [CRC7_W-1:0] crc_d;
  logic [CRC7_W-1:0] base_c;

  // Clear and enable may coincide: the bit is folded into a freshly zeroed register.
  always_comb begin
    base_c = clear_i ? '0 : crc_q;
    crc_d  = en_i ? crc7_step(base_c, din_i) : base_c;
  end

  // CRC state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_serializer.sv
// SD host CMD-line serializer: shifts a frame out MSB-first, optionally
// replacing the low byte with the running CRC7 and the end bit.
module sd_cmd_serializer
  import sd_cmd_pkg::*;
#(
  parameter int unsigned N_BITS = CMD_FRAME_BITS,
  parameter bit          CRC_EN = 1'b1,
  parameter int unsigned CNT_W  = $clog2(N_BITS + 1)
) (
  input  logic              sd_clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              load_send,
  input  logic [N_BITS-1:0] parallel,
  output logic              serial,
  output logic              serial_oe,
  output logic              busy,
  output logic              complete
);

  localparam logic [CNT_W-1:0] LAST_IDX     = CNT_W'(N_BITS - 1);
  localparam logic [CNT_W-1:0] CRC_START    = CNT_W'(N_BITS - 8);
  localparam logic [CNT_W-1:0] CRC_LAST_SEL = CNT_W'(N_BITS - 2);

  sd_cmd_state_e     state_q, state_d;
  logic [N_BITS-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;   // index of the bit currently on the line
  logic              serial_q, serial_d;
  logic              oe_q, oe_d;
  logic              busy_q, busy_d;
  logic              complete_q, complete_d;

  logic              crc_clear_c;
  logic              crc_en_c;
  logic              crc_din_c;
  logic [CRC7_W-1:0] crc_c;
  logic [2:0]        crc_idx_c;

  // The CRC absorbs each data bit as it is put on the line, so it is final
  // by the time the first CRC bit has to be registered onto serial.
  crc7_serial u_crc (
    .clk_i   (sd_clock),
    .rst_i   (reset),
    .clear_i (crc_clear_c),
    .en_i    (crc_en_c),
    .din_i   (crc_din_c),
    .crc_o   (crc_c)
  );

  // Next-state, shift/count update, and registered-output selection.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    serial_d    = 1'b1;
    oe_d        = 1'b0;
    busy_d      = 1'b0;
    complete_d  = 1'b0;
    crc_clear_c = 1'b0;
    crc_en_c    = 1'b0;
    crc_din_c   = 1'b0;
    crc_idx_c   = 3'(CRC_LAST_SEL - cnt_q);

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (load_send) begin
            state_d     = SHIFT;
            sreg_d      = parallel;
            cnt_d       = '0;
            crc_clear_c = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            sreg_d = {sreg_q[N_BITS-2:0], 1'b0};
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs describe the bit that will be on the line after this edge.
    if (state_d == SHIFT) begin
      oe_d      = 1'b1;
      crc_idx_c = 3'(CRC_LAST_SEL - cnt_d);
      if (CRC_EN && (cnt_d >= CRC_START)) begin
        serial_d = (cnt_d == LAST_IDX) ? 1'b1 : crc_c[crc_idx_c];
      end else begin
        serial_d = sreg_d[N_BITS-1];
      end
      if (CRC_EN && (cnt_d < CRC_START)) begin
        crc_en_c  = 1'b1;
        crc_din_c = sreg_d[N_BITS-1];
      end
    end
    busy_d     = (state_d != IDLE);
    complete_d = (state_d == DONE);
  end

  // State and output registers, synchronous active-high reset.
  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      cnt_q      <= '0;
      serial_q   <= 1'b1;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      cnt_q      <= cnt_d;
      serial_q   <= serial_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      complete_q <= complete_d;
    end
  end

  assign serial    = serial_q;
  assign serial_oe = oe_q;
  assign busy      = busy_q;
  assign complete  = complete_q;

endmodule

// File: tb/tb_sd_cmd_serializer.sv
// Scoreboard bench for sd_cmd_serializer: CRC7 48-bit, raw 48-bit and raw 136-bit instances.
module tb_sd_cmd_serializer;

  typedef struct {
    int           id;
    logic [135:0] data;
    int           len;
    int           k;
    bit           abort;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic load0 = 1'b0, load1 = 1'b0, load2 = 1'b0;
  logic [47:0]  par0 = '0, par1 = '0;
  logic [135:0] par2 = '0;
  logic ser0, oe0, busy0, cmp0;
  logic ser1, oe1, busy1, cmp1;
  logic ser2, oe2, busy2, cmp2;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  exp_t         sb[$];
  logic [135:0] sbuf   [0:2];
  int           bitcnt [0:2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sd_cmd_serializer #(.N_BITS(48), .CRC_EN(1'b1)) u_crc48 (
    .sd_clock(clk), .reset(reset), .enable(enable), .load_send(load0),
    .parallel(par0), .serial(ser0), .serial_oe(oe0), .busy(busy0), .complete(cmp0));

  sd_cmd_serializer #(.N_BITS(48), .CRC_EN(1'b0)) u_raw48 (
    .sd_clock(clk), .reset(reset), .enable(enable), .load_send(load1),
    .parallel(par1), .serial(ser1), .serial_oe(oe1), .busy(busy1), .complete(cmp1));

  sd_cmd_serializer #(.N_BITS(136), .CRC_EN(1'b0)) u_raw136 (
    .sd_clock(clk), .reset(reset), .enable(enable), .load_send(load2),
    .parallel(par2), .serial(ser2), .serial_oe(oe2), .busy(busy2), .complete(cmp2));

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-instance monitor step: collects driven bits, closes frames on oe drop.
  task automatic mon_step(input int id, input int n, input logic ser, input logic oe,
                          input logic cmp, input logic bsy);
    exp_t e;
    chk($sformatf("busy%0d", id), 136'(bsy), 136'(oe | cmp));
    if (oe !== 1'b1) chk($sformatf("idle_serial%0d", id), 136'(ser), 136'(1'b1));
    if (oe === 1'b1) begin
      if (bitcnt[id] == 0) begin
        sbuf[id] = '0;
        if (sb.size() == 0 || sb[0].id != id) begin
          checks++; fails++;
          $display("[TB] FAIL unexpected_frame%0d: got start at cycle %0d expected none", id, cyc);
        end else begin
          chk($sformatf("start_cycle%0d", id), 136'(cyc), 136'(sb[0].k));
        end
      end
      sbuf[id] = {sbuf[id][134:0], ser};
      bitcnt[id]++;
    end else if (bitcnt[id] != 0 || cmp === 1'b1) begin
      if (sb.size() == 0 || sb[0].id != id) begin
        checks++; fails++;
        $display("[TB] FAIL unexpected_end%0d: got complete=%0b bits=%0d expected none", id, cmp, bitcnt[id]);
      end else begin
        e = sb.pop_front();
        chk($sformatf("complete%0d", id), 136'(cmp), 136'(!e.abort));
        chk($sformatf("oe_len%0d", id), 136'(bitcnt[id]), 136'(e.len));
        if (!e.abort) begin
          chk($sformatf("frame%0d", id), sbuf[id], e.data);
          chk($sformatf("complete_cycle%0d", id), 136'(cyc), 136'(e.k + n));
        end
      end
      bitcnt[id] = 0;
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_step(0, 48, ser0, oe0, cmp0, busy0);
      mon_step(1, 48, ser1, oe1, cmp1, busy1);
      mon_step(2, 136, ser2, oe2, cmp2, busy2);
    end
  end

  task automatic do_accept(input int id, input logic [135:0] par, input logic [135:0] exp,
                           input int elen, input bit ab);
    exp_t e;
    @(negedge clk);
    case (id)
      0: begin par0 = par[47:0]; load0 = 1'b1; end
      1: begin par1 = par[47:0]; load1 = 1'b1; end
      default: begin par2 = par; load2 = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    e.id = id; e.data = exp; e.len = elen; e.k = cyc; e.abort = ab;
    sb.push_back(e);
    load0 = 1'b0; load1 = 1'b0; load2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bitcnt[0] = 0; bitcnt[1] = 0; bitcnt[2] = 0;
    sbuf[0] = '0; sbuf[1] = '0; sbuf[2] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_serial0", 136'(ser0), 136'(1'b1));
    chk("rst_oe0", 136'(oe0), 136'(1'b0));
    chk("rst_busy0", 136'(busy0), 136'(1'b0));
    chk("rst_complete0", 136'(cmp0), 136'(1'b0));
    chk("rst_serial2", 136'(ser2), 136'(1'b1));
    chk("rst_oe2", 136'(oe2), 136'(1'b0));
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);

    // CRC7 frames: low byte of parallel is don't-care.
    do_accept(0, 136'(48'h40_0000_0000_FF), 136'(48'h40_0000_0000_95), 48, 1'b0);
    repeat (52) @(posedge clk);
    do_accept(0, 136'(48'h48_0000_01AA_00), 136'(48'h48_0000_01AA_87), 48, 1'b0);
    repeat (52) @(posedge clk);
    do_accept(0, 136'(48'h51_0000_0000_33), 136'(48'h51_0000_0000_55), 48, 1'b0);
    repeat (52) @(posedge clk);

    // Back-to-back at k and k+49, with an ignored load_send at k+10.
    do_accept(0, 136'(48'h40_0000_0000_00), 136'(48'h40_0000_0000_95), 48, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    load0 = 1'b1; par0 = 48'h48_0000_01AA_00;
    @(posedge clk);
    #1 load0 = 1'b0;
    repeat (38) @(posedge clk);
    do_accept(0, 136'(48'h51_0000_0000_00), 136'(48'h51_0000_0000_55), 48, 1'b0);
    repeat (52) @(posedge clk);

    // Abort by enable after bit index 20 is on the line: 21 bits driven.
    do_accept(0, 136'(48'h48_0000_01AA_00), 136'(0), 21, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1 enable = 1'b1;
    repeat (3) @(posedge clk);

    // Reset after bit index 30 with load_send held: 31 bits driven.
    do_accept(0, 136'(48'h51_0000_0000_00), 136'(0), 31, 1'b1);
    repeat (30) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; load0 = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; load0 = 1'b0;
    repeat (3) @(posedge clk);

    // Fresh frame after aborts must carry a clean CRC.
    do_accept(0, 136'(48'h48_0000_01AA_FF), 136'(48'h48_0000_01AA_87), 48, 1'b0);
    repeat (52) @(posedge clk);

    // Verbatim frames.
    do_accept(1, 136'(48'hA5A5_5A5A_F00F), 136'(48'hA5A5_5A5A_F00F), 48, 1'b0);
    repeat (52) @(posedge clk);
    do_accept(2, 136'hC35A960F1E2D3C4B5A69788796A5B4C3E1,
                 136'hC35A960F1E2D3C4B5A69788796A5B4C3E1, 136, 1'b0);
    repeat (140) @(posedge clk);

    @(negedge clk);
    chk("scoreboard_empty", 136'(sb.size()), 136'(0));
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
